// File: rtl/systolic_drain.sv
// Serialises a parallel set of PE results onto a valid/ready stream, one lane per transfer.
// Results are snapshotted on an accepted start so the array can move on immediately.
module systolic_drain #(
  parameter int unsigned PE_NUMBER = 3,
  parameter int unsigned RES_W     = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [RES_W-1:0] pe_res [0:PE_NUMBER-1],
  input  logic             out_ready,
  output logic             out_valid,
  output logic [RES_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             drop_err
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(PE_NUMBER - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RES_W-1:0] shadow_q [0:PE_NUMBER-1];
  logic [RES_W-1:0] shadow_d [0:PE_NUMBER-1];
  logic             valid_q, valid_d;
  logic [RES_W-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;

  logic [IDX_W-1:0] idx_inc;
  logic [RES_W-1:0] next_data;

  assign idx_inc = idx_q + IDX_W'(1);

  // Explicit compare-mux keeps the lane select free of index-width mismatches.
  always_comb begin
    next_data = '0;
    for (int i = 0; i < int'(PE_NUMBER); i++) begin
      if (idx_inc == IDX_W'(i)) next_data = shadow_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    done_d   = 1'b0;
    drop_d   = drop_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shadow_d = pe_res;
          idx_d    = '0;
          valid_d  = 1'b1;
          data_d   = pe_res[0];
          last_d   = (LastIdx == '0);
          state_d  = StSend;
        end
      end
      StSend: begin
        if (start) drop_d = 1'b1;
        // out_valid is always high here, so out_ready alone marks a transfer.
        if (out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            idx_d  = idx_inc;
            data_d = next_data;
            last_d = (idx_inc == LastIdx);
          end
        end
      end
      StDone: begin
        if (start) drop_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      shadow_q <= '{default: '0};
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign drop_err  = drop_q;

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001: Parameter PE_NUMBER, default 3, number of result lanes (one per PE row); legal range 1..16.
REQ-002: Parameter RES_W, default 16, width of each PE result and of out_data.
REQ-003: Parameter IDX_W, default 4, width of out_idx; IDX_W SHALL satisfy 2**IDX_W >= PE_NUMBER.
REQ-004: clk  input  1  sole clock; all state updates on posedge clk.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: start  input  1  single-cycle pulse from the Controller; pe_res is valid and stable in this cycle.
REQ-007: pe_res  input  RES_W x PE_NUMBER (unpacked [0:PE_NUMBER-1])  parallel accumulator results from the Systolic_array.
REQ-008: out_ready  input  1  downstream sink accepts the current element.
REQ-009: out_valid  output  1  out_data/out_idx/out_last hold a valid element.
REQ-010: out_data  output  RES_W  current result element.
REQ-011: out_idx  output  IDX_W  lane index of out_data.
REQ-012: out_last  output  1  current element is lane PE_NUMBER-1.
REQ-013: busy  output  1  high in every state except IDLE.
REQ-014: done  output  1  one-cycle pulse after the final element is accepted.
REQ-015: drop_err  output  1  sticky flag: a start pulse was ignored.

Function
REQ-016: FSM states SHALL be IDLE, SEND, DONE; all outputs SHALL be registered.
REQ-017: IDLE + start=1: capture all pe_res lanes into the shadow registers, set idx=0, go to SEND.
REQ-018: SEND SHALL drive out_valid=1, out_data=shadow[idx], out_idx=idx, out_last=(idx==PE_NUMBER-1).
REQ-019: Latency: a start at posedge T SHALL yield out_valid=1 with lane 0 visible after posedge T+1.
REQ-020: An element SHALL transfer on a posedge where out_valid=1 and out_ready=1; otherwise out_data, out_idx and out_last SHALL hold unchanged.
REQ-021: A transfer with out_last=0 SHALL increment idx; at full rate (out_ready held at 1) exactly one element SHALL be emitted per cycle.
REQ-022: A transfer with out_last=1 SHALL move the FSM to DONE; out_valid SHALL be 0 in DONE.
REQ-023: DONE SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-024: start in SEND or DONE SHALL be ignored, SHALL leave the shadow registers unchanged, and SHALL set drop_err=1.
REQ-025: start in the same cycle that DONE returns to IDLE SHALL be ignored (drop_err=1); start is accepted only while in IDLE.
REQ-026: drop_err SHALL be cleared only by reset.
REQ-027: pe_res SHALL be sampled only on an accepted start; later changes to pe_res SHALL not affect out_data.
REQ-028: With PE_NUMBER=1, out_last=1 on the first element, and SEND SHALL be followed directly by DONE.
REQ-029: out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-030: reset=1 at any posedge SHALL force state IDLE, idx=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0, drop_err=0, and shadow registers=0.
REQ-031: reset SHALL take priority over start and over any in-flight transfer; a transfer partially drained at reset SHALL be discarded and not resumed.
REQ-032: The first cycle after reset deasserts SHALL accept start.

Verification
REQ-033: pe_res={62,51,64}, start pulse, out_ready=1 -> out_data 62,51,64 on three consecutive cycles starting at T+1, idx 0,1,2, out_last on 64, done one cycle later, busy=0 after that.
REQ-034: Same data with out_ready toggling 0,1,0,0,1,1 -> each element holds stable while out_ready=0; order and values are unchanged; done pulses once.
REQ-035: Second start during SEND with pe_res={1,2,3} -> original 62,51,64 still emitted, drop_err=1 and stays 1 until reset.
REQ-036: reset asserted after lane 0 is accepted -> next cycle all outputs are 0 and state is IDLE; a new start with {8,10,4} emits 8,10,4 from idx 0.
REQ-037: pe_res changed to {9,9,9} the cycle after start -> emitted data remains the values captured at start.
REQ-038: PE_NUMBER=1, pe_res={7}, out_ready=1 -> a single element 7 with out_last=1, then done.
